axi_burst_addr_gen: RTL
=======================

// Module: axi_burst_addr_gen
// PURPOSE
//  Expands one AXI burst command (addr/len/size/type) into a per-beat stream: address, byte strobe, last flag.
//  Sits directly upstream of the axi_top data path and drives its per-beat write/read address and lane enables.
//  Rejects illegal commands before any beat is issued.
// PARAMETERS
//  ADDR_W      64  address width
//  LEN_W       8   burst length field width (beats-1)
//  DATA_BYTES  16  data bus width in bytes (128-bit bus); power of 2
// PORTS
//  clk         in   1           clock; all logic on rising edge
//  reset       in   1           asynchronous, active-high reset
//  cmd_valid   in   1           command offered
//  cmd_ready   out  1           block idle, command can be accepted
//  cmd_addr    in   ADDR_W      start address, may be unaligned
//  cmd_len     in   LEN_W       beats-1
//  cmd_size    in   3           bytes per beat = 2**cmd_size
//  cmd_burst   in   2           00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//  beat_valid  out  1           beat available
//  beat_ready  in   1           downstream accepts beat
//  beat_addr   out  ADDR_W      beat address
//  beat_strb   out  DATA_BYTES  active byte lanes for this beat
//  beat_last   out  1           final beat of burst
//  beat_idx    out  LEN_W       beat number, 0-based
//  cmd_err     out  1           one-cycle pulse: command rejected
// BEHAVIOUR
//  Reset: state IDLE, cmd_ready=1, beat_valid=0, beat_addr=0, beat_strb=0, beat_last=0, beat_idx=0, cmd_err=0.
//  Reset mid-burst: remaining beats are dropped; outputs return to reset values immediately.
//  FSM IDLE -> BURST on cmd_valid&cmd_ready with a legal command.
//   BURST -> IDLE on beat_valid&beat_ready&beat_last.
//  cmd_ready = (state==IDLE); it is low for the whole burst.
//   It rises the cycle after the last beat handshake; back-to-back acceptance in that same cycle is not allowed.
//  Illegal command: 2**cmd_size > DATA_BYTES; cmd_burst==11; WRAP with cmd_len not in {1,3,7,15};
//   INCR whose last byte crosses a 4 KB boundary.
//   Response: the command is consumed, cmd_err pulses for 1 cycle the next cycle, state stays IDLE, no beats issued.
//  First beat: beat_valid=1 one cycle after acceptance; beat_addr=cmd_addr (unaligned kept); beat_idx=0.
//  Handshake: beat_addr/strb/last/idx are held stable while beat_valid&!beat_ready.
//   They advance only on beat_valid&beat_ready; beat_valid never drops mid-burst.
//  Next address, with B=2**size and A=beat_addr&~(B-1):
//   FIXED: beat_addr unchanged (first address, unaligned kept).
//   INCR:  A+B.
//   WRAP:  W=B*(len+1), low=cmd_addr&~(W-1); next=A+B, and if next==low+W then next=low.
//  Address arithmetic is ADDR_W wide and truncates; no carry out.
//  beat_strb: lanes [off, end) with off=beat_addr mod DATA_BYTES and end=(A mod DATA_BYTES)+B.
//   Unaligned first beat therefore covers only its tail bytes.
//  beat_last = (beat_idx==len); after len+1 handshakes the block returns to IDLE.
// STRUCTURE
//  axi_pkg: burst_t enum (FIXED/INCR/WRAP/RSVD), ADDR_W, DATA_BYTES, LEN_W, 4 KB boundary constant.
//  Sub-module axi_strb_gen: combinational (beat_addr, size) -> beat_strb.
//  Top keeps the FSM, beat counter, address update and legality check.
// TESTING
//  1 INCR addr=0x1000 size=3 len=3, ready=1: addrs 0x1000,0x1008,0x1010,0x1018;
//    strb 0x00FF,0xFF00,0x00FF,0xFF00; last on beat 3.
//  2 WRAP addr=0x1034 size=2 len=3: addrs 0x1034,0x1038,0x103C,0x1030; last on 0x1030.
//  3 FIXED addr=0x2005 size=0 len=2 with beat_ready toggling 1/0: addr 0x2005 x3, strb 0x0020;
//    outputs held stable while ready=0.
//  4 INCR addr=0xFF8 size=3 len=1 (crosses 4 KB): cmd_err pulses 1 cycle, beat_valid stays 0,
//    cmd_ready back to 1.
//  5 Unaligned INCR addr=0x1003 size=2 len=1: beat0 0x1003 strb 0x0008, beat1 0x1004 strb 0x00F0.
//  6 Assert reset after beat 1 of an INCR len=7 burst: beat_valid=0 and cmd_ready=1 immediately;
//    a new command is accepted after reset release.

Source files
------------

// File: rtl/axi_burst_addr_gen_pkg.sv
// Shared types and constants for the AXI burst address generator.
package axi_burst_addr_gen_pkg;

    localparam int DEF_ADDR_W     = 64;
    localparam int DEF_LEN_W      = 8;
    localparam int DEF_DATA_BYTES = 16;

    // A 4 KB page is addressed by the bits above this index.
    localparam int PAGE_4K_SHIFT  = 12;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

endpackage

// File: rtl/axi_burst_addr_gen_strb.sv
// Byte-lane enable generator: lanes [addr offset, aligned offset + beat bytes).
module axi_burst_addr_gen_strb #(
    parameter int DATA_BYTES = 16
) (
    input  logic [$clog2(DATA_BYTES)-1:0] addr_low,
    input  logic [2:0]                    size,
    output logic [DATA_BYTES-1:0]         strb
);

    localparam int OFF_W = $clog2(DATA_BYTES);

    logic [OFF_W:0]   lane_bytes;
    logic [OFF_W:0]   lane_mask;
    logic [OFF_W:0]   lane_start;
    logic [OFF_W:0]   lane_end;

    // Start lane keeps the unaligned offset; end lane is computed from the aligned beat.
    always_comb begin
        lane_bytes = (OFF_W+1)'(1) << size;
        lane_mask  = ~(lane_bytes - (OFF_W+1)'(1));
        lane_start = {1'b0, addr_low};
        lane_end   = ({1'b0, addr_low} & lane_mask) + lane_bytes;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
            assign strb[gi] = ((OFF_W+1)'(gi) >= lane_start) && ((OFF_W+1)'(gi) < lane_end);
        end
    endgenerate

endmodule

// File: rtl/axi_burst_addr_gen.sv
// Expands one AXI burst command into per-beat address, strobe and last flag.
// Illegal commands are consumed and answered with a one-cycle cmd_err pulse.
module axi_burst_addr_gen
    import axi_burst_addr_gen_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int DATA_BYTES = DEF_DATA_BYTES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [1:0]            cmd_burst,
    output logic                  beat_valid,
    input  logic                  beat_ready,
    output logic [ADDR_W-1:0]     beat_addr,
    output logic [DATA_BYTES-1:0] beat_strb,
    output logic                  beat_last,
    output logic [LEN_W-1:0]      beat_idx,
    output logic                  cmd_err
);

    localparam int         OFF_W    = $clog2(DATA_BYTES);
    localparam logic [2:0] MAX_SIZE = 3'(OFF_W);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   beat_addr_reg, beat_addr_next;
    logic [LEN_W-1:0]    beat_idx_reg;
    logic [LEN_W-1:0]    len_reg;
    logic [2:0]          size_reg;
    burst_t              burst_reg;
    logic [ADDR_W-1:0]   wrap_low_reg, wrap_high_reg;
    logic                cmd_err_reg;

    burst_t              cmd_burst_t;
    logic [ADDR_W-1:0]   cmd_beat_bytes, cmd_total_bytes, cmd_aligned, cmd_last_byte;
    logic                cmd_crosses_4k, cmd_wrap_len_ok, cmd_illegal;
    logic                cmd_accept, beat_fire;
    logic [ADDR_W-1:0]   beat_bytes, beat_aligned, beat_incr;
    logic [DATA_BYTES-1:0] strb_raw;

    assign cmd_accept = cmd_valid & cmd_ready;
    assign beat_fire  = beat_valid & beat_ready;

    // Legality check on the offered command, including the 4 KB page rule for INCR.
    always_comb begin
        cmd_burst_t     = burst_t'(cmd_burst);
        cmd_beat_bytes  = ADDR_W'(1) << cmd_size;
        cmd_total_bytes = (ADDR_W'(cmd_len) + ADDR_W'(1)) << cmd_size;
        cmd_aligned     = cmd_addr & ~(cmd_beat_bytes - ADDR_W'(1));
        cmd_last_byte   = cmd_aligned + cmd_total_bytes - ADDR_W'(1);
        cmd_crosses_4k  = cmd_addr[ADDR_W-1:PAGE_4K_SHIFT] != cmd_last_byte[ADDR_W-1:PAGE_4K_SHIFT];
        cmd_wrap_len_ok = (cmd_len == LEN_W'(1)) || (cmd_len == LEN_W'(3)) ||
                          (cmd_len == LEN_W'(7)) || (cmd_len == LEN_W'(15));
        cmd_illegal     = (cmd_size > MAX_SIZE) ||
                          (cmd_burst_t == BURST_RSVD) ||
                          ((cmd_burst_t == BURST_WRAP) && !cmd_wrap_len_ok) ||
                          ((cmd_burst_t == BURST_INCR) && cmd_crosses_4k);
    end

    // Next beat address from the aligned current beat; WRAP folds back to the window base.
    always_comb begin
        beat_bytes   = ADDR_W'(1) << size_reg;
        beat_aligned = beat_addr_reg & ~(beat_bytes - ADDR_W'(1));
        beat_incr    = beat_aligned + beat_bytes;
        case (burst_reg)
            BURST_INCR: beat_addr_next = beat_incr;
            BURST_WRAP: beat_addr_next = (beat_incr == wrap_high_reg) ? wrap_low_reg : beat_incr;
            default:    beat_addr_next = beat_addr_reg;
        endcase
    end

    // Burst context capture on acceptance and per-beat address/counter advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_addr_reg <= '0;
            beat_idx_reg  <= '0;
            len_reg       <= '0;
            size_reg      <= '0;
            burst_reg     <= BURST_FIXED;
            wrap_low_reg  <= '0;
            wrap_high_reg <= '0;
            cmd_err_reg   <= 1'b0;
        end else begin
            cmd_err_reg <= cmd_accept & cmd_illegal;
            if (cmd_accept && !cmd_illegal) begin
                beat_addr_reg <= cmd_addr;
                beat_idx_reg  <= '0;
                len_reg       <= cmd_len;
                size_reg      <= cmd_size;
                burst_reg     <= cmd_burst_t;
                wrap_low_reg  <= cmd_addr & ~(cmd_total_bytes - ADDR_W'(1));
                wrap_high_reg <= (cmd_addr & ~(cmd_total_bytes - ADDR_W'(1))) + cmd_total_bytes;
            end else if (beat_fire) begin
                beat_addr_reg <= beat_addr_next;
                beat_idx_reg  <= beat_idx_reg + LEN_W'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // FSM next state: legal accept starts a burst, last-beat handshake ends it.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (cmd_accept && !cmd_illegal) state_next = ST_BURST;
            ST_BURST: if (beat_fire && beat_last)     state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        cmd_ready  = (state_reg == ST_IDLE);
        beat_valid = (state_reg == ST_BURST);
        beat_last  = (state_reg == ST_BURST) && (beat_idx_reg == len_reg);
    end

    axi_burst_addr_gen_strb #(
        .DATA_BYTES (DATA_BYTES)
    ) u_strb (
        .addr_low (beat_addr_reg[OFF_W-1:0]),
        .size     (size_reg),
        .strb     (strb_raw)
    );

    assign beat_addr = beat_addr_reg;
    assign beat_idx  = beat_idx_reg;
    assign beat_strb = beat_valid ? strb_raw : '0;
    assign cmd_err   = cmd_err_reg;

endmodule
